// File: rtl/exe_stage_mc_if.sv
// Issue/result bundle between the decode stage, the execute stage and the
// writeback consumers. The master drives an instruction in; the slave returns results.
interface exe_stage_mc_if #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SHAMT_W    = 5
);
    logic                  in_valid;
    logic [3:0]            alu_op;
    logic [SHAMT_W-1:0]    shamt;
    logic                  reg_dst;
    logic                  is_imm;
    logic [3:0]            wb_ctrl;
    logic [WIDTH-1:0]      in1;
    logic [WIDTH-1:0]      in2;
    logic [WIDTH-1:0]      imm;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic [WIDTH-1:0]      mem_fwd_data;
    logic [WIDTH-1:0]      wb_fwd_data;
    logic                  flush;

    logic                  busy;
    logic                  out_valid;
    logic [WIDTH-1:0]      alu_out;
    logic [WIDTH-1:0]      mem_input;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic [3:0]            ns_control;

    modport master (
        output in_valid, alu_op, shamt, reg_dst, is_imm, wb_ctrl,
               in1, in2, imm, rt, rd, fwd_a, fwd_b,
               mem_fwd_data, wb_fwd_data, flush,
        input  busy, out_valid, alu_out, mem_input, dest_reg, ns_control
    );

    modport slave (
        input  in_valid, alu_op, shamt, reg_dst, is_imm, wb_ctrl,
               in1, in2, imm, rt, rd, fwd_a, fwd_b,
               mem_fwd_data, wb_fwd_data, flush,
        output busy, out_valid, alu_out, mem_input, dest_reg, ns_control
    );
endinterface

// File: rtl/exe_stage_mc.sv
// Execute stage: single-cycle ALU ops with forwarding, plus a multi-cycle
// shift-add multiplier that stalls issue via busy for WIDTH cycles.
module exe_stage_mc #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SHAMT_W    = 5
) (
    input logic          clk,
    input logic          reset,
    exe_stage_mc_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [WIDTH-1:0]      mcand_q;
    logic [WIDTH-1:0]      mplier_q;
    logic [WIDTH-1:0]      acc_q;
    logic [REG_ADDR_W-1:0] p_dest_q;
    logic [3:0]            p_ctrl_q;
    logic [WIDTH-1:0]      p_mem_q;

    logic                  out_valid_q;
    logic [WIDTH-1:0]      alu_out_q;
    logic [WIDTH-1:0]      mem_input_q;
    logic [REG_ADDR_W-1:0] dest_reg_q;
    logic [3:0]            ns_control_q;

    logic [WIDTH-1:0]      reg_opnd [2];
    logic [1:0]            fwd_sel  [2];
    logic [WIDTH-1:0]      fwd_opnd [2];
    logic [WIDTH-1:0]      op_a;
    logic [WIDTH-1:0]      op_b;
    logic [SHAMT_W-1:0]    sh;
    logic [WIDTH-1:0]      alu_result;
    logic [WIDTH-1:0]      acc_d;
    logic [REG_ADDR_W-1:0] dest_sel;
    logic                  accept;

    assign reg_opnd[0] = bus.in1;
    assign reg_opnd[1] = bus.in2;
    assign fwd_sel[0]  = bus.fwd_a;
    assign fwd_sel[1]  = bus.fwd_b;

    // Both operands share the same forwarding mux; 2'b11 falls back to the register value.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_opnd[gi] = (fwd_sel[gi] == 2'b01) ? bus.mem_fwd_data :
                                  (fwd_sel[gi] == 2'b10) ? bus.wb_fwd_data  :
                                                           reg_opnd[gi];
        end
    endgenerate

    assign op_a     = fwd_opnd[0];
    assign op_b     = bus.is_imm ? bus.imm : fwd_opnd[1];
    assign sh       = bus.shamt;
    assign dest_sel = bus.reg_dst ? bus.rd : bus.rt;
    assign accept   = bus.in_valid && !bus.flush && (state_q == S_IDLE);
    assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        alu_result = '0;
        case (bus.alu_op)
            4'd0: alu_result = op_a + op_b;
            4'd1: alu_result = op_a - op_b;
            4'd2: alu_result = op_a & op_b;
            4'd3: alu_result = op_a | op_b;
            4'd4: alu_result = op_a ^ op_b;
            4'd5: alu_result = ~(op_a | op_b);
            4'd6: alu_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd7: alu_result = op_a << sh;
            4'd8: alu_result = op_a >> sh;
            4'd9: alu_result = $signed(op_a) >>> sh;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            p_dest_q     <= '0;
            p_ctrl_q     <= '0;
            p_mem_q      <= '0;
            out_valid_q  <= 1'b0;
            alu_out_q    <= '0;
            mem_input_q  <= '0;
            dest_reg_q   <= '0;
            ns_control_q <= '0;
        end else begin
            // Result registers hold by default; only the valid/control pulse is cleared.
            out_valid_q  <= 1'b0;
            ns_control_q <= 4'b0000;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (bus.alu_op == OP_MUL) begin
                            state_q  <= S_MUL;
                            cnt_q    <= '0;
                            mcand_q  <= op_a;
                            mplier_q <= op_b;
                            acc_q    <= '0;
                            p_dest_q <= dest_sel;
                            p_ctrl_q <= bus.wb_ctrl;
                            p_mem_q  <= fwd_opnd[1];
                        end else begin
                            out_valid_q  <= 1'b1;
                            alu_out_q    <= alu_result;
                            mem_input_q  <= fwd_opnd[1];
                            dest_reg_q   <= dest_sel;
                            ns_control_q <= bus.wb_ctrl;
                        end
                    end
                end
                S_MUL: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q      <= S_IDLE;
                            out_valid_q  <= 1'b1;
                            alu_out_q    <= acc_d;
                            mem_input_q  <= p_mem_q;
                            dest_reg_q   <= p_dest_q;
                            ns_control_q <= p_ctrl_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = (state_q == S_MUL);
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_out    = alu_out_q;
    assign bus.mem_input  = mem_input_q;
    assign bus.dest_reg   = dest_reg_q;
    assign bus.ns_control = ns_control_q;
endmodule
